// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit, its data bus and the load extender.
package Types;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } DataAccess;

  typedef logic [31:0] Data;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } LsuState;

  // BYTE accesses can never be misaligned.
  function automatic logic is_misaligned(input DataAccess access, input logic [1:0] addr_lo);
    return ((access == HALF) && addr_lo[0]) || ((access == WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/DataBus.sv
// Data memory bus: the master drives the request fields, the slave returns
// combinational read data and writes on the clock edge when we is high.
interface DataBus;
  logic [31:0]     addr;
  Types::DataAccess access;
  logic            we;
  Types::Data      wdata;
  Types::Data      rdata;

  modport master (output addr, output access, output we, output wdata, input rdata);
  modport slave  (input addr, input access, input we, input wdata, output rdata);
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of raw load data by access size; purely combinational
// so the writeback stage can reuse it.
module lsu_load_extend
  import Types::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  access,
  input  logic        unsigned_ext,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (access)
      BYTE:    result = {{24{~unsigned_ext & raw[7]}}, raw[7:0]};
      HALF:    result = {{16{~unsigned_ext & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time onto DataBus. Define LSU_MISALIGN_EN
// to split misaligned accesses into byte beats; otherwise they fault.
module load_store_unit
  import Types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [1:0]            i_access,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_error,
  DataBus.master                bus
);

  LsuState               state, state_next;
  logic                  accept, misaligned_in, fault_in, split, last_beat;
  logic [1:0]            beat_cnt, last_idx;
  logic                  we_q, unsigned_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  DataAccess             access_q;
  logic [DATA_WIDTH-1:0] wdata_q, asm_q, asm_next, ext_data, rdata_q;

  assign o_ready       = (state == IDLE) || (state == DONE);
  assign accept        = i_req && o_ready;
  assign misaligned_in = is_misaligned(DataAccess'(i_access), i_addr[1:0]);
  assign o_valid       = (state == DONE);
  assign o_rdata       = rdata_q;

`ifdef LSU_MISALIGN_EN
  logic split_q;

  always_ff @(posedge i_clock) begin
    if (accept) split_q <= misaligned_in;
  end

  assign split    = split_q;
  assign fault_in = 1'b0;
  assign o_error  = 1'b0;
`else
  logic error_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset)    error_q <= 1'b0;
    else if (accept) error_q <= misaligned_in;
  end

  assign split    = 1'b0;
  assign fault_in = misaligned_in;
  assign o_error  = error_q;
`endif

  always_comb begin
    last_idx = 2'd0;
    if (split) last_idx = (access_q == HALF) ? 2'd1 : 2'd3;
  end
  assign last_beat = (beat_cnt == last_idx);

  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = fault_in ? DONE : ACCESS;
        else        state_next = IDLE;
      end
      ACCESS:  if (last_beat) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset)                            beat_cnt <= 2'd0;
    else if (accept)                         beat_cnt <= 2'd0;
    else if (state == ACCESS && !last_beat)  beat_cnt <= beat_cnt + 2'd1;
  end

  // Request latch and byte assembly; no reset needed, consumed only in ACCESS.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      we_q       <= i_we;
      addr_q     <= i_addr;
      access_q   <= DataAccess'(i_access);
      unsigned_q <= i_unsigned;
      wdata_q    <= i_wdata;
      asm_q      <= '0;
    end else if (state == ACCESS) begin
      asm_q      <= asm_next;
    end
  end

  // Split beats contribute one little-endian byte each; aligned beats the whole word.
  always_comb begin
    asm_next = asm_q;
    if (split) asm_next[{beat_cnt, 3'b000} +: 8] = bus.rdata[7:0];
    else       asm_next = bus.rdata;
  end

  lsu_load_extend u_extend (
    .raw          (asm_next),
    .access       (access_q),
    .unsigned_ext (unsigned_q),
    .result       (ext_data)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset)                           rdata_q <= '0;
    else if (accept && fault_in)            rdata_q <= '0;
    else if (state == ACCESS && last_beat)  rdata_q <= we_q ? '0 : ext_data;
  end

  always_comb begin
    bus.we     = 1'b0;
    bus.addr   = '0;
    bus.access = WORD;
    bus.wdata  = '0;
    if (state == ACCESS) begin
      bus.we = we_q;
      if (split) begin
        bus.addr   = addr_q + ADDR_WIDTH'(beat_cnt);
        bus.access = BYTE;
        bus.wdata  = {24'b0, wdata_q[{beat_cnt, 3'b000} +: 8]};
      end else begin
        bus.addr   = addr_q;
        bus.access = access_q;
        bus.wdata  = wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-array memory slave.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          beats;
  } exp_t;

  logic        clk, rst_n, req, we, uns;
  logic        ready, valid, error;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  access;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          st_beats = 0;
  exp_t        exp_q[$];

  // Both memories alias on the low address byte; test regions are chosen not to collide.
  logic [7:0]  mem     [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] slave_rdata;

  DataBus bus_if ();

  load_store_unit dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_req      (req),
    .o_ready    (ready),
    .i_we       (we),
    .i_addr     (addr),
    .i_access   (access),
    .i_unsigned (uns),
    .i_wdata    (wdata),
    .o_valid    (valid),
    .o_rdata    (rdata),
    .o_error    (error),
    .bus        (bus_if)
  );

  function automatic int nbytes(input logic [1:0] acc);
    return (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    slave_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (i < nbytes(bus_if.access)) slave_rdata[8*i +: 8] = mem[8'(bus_if.addr + 32'(i))];
  end
  assign bus_if.rdata = slave_rdata;

  always @(posedge clk) begin
    if (bus_if.we)
      for (int i = 0; i < 4; i++)
        if (i < nbytes(bus_if.access)) mem[8'(bus_if.addr + 32'(i))] <= bus_if.wdata[8*i +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts store beats and checks each completion against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        st_beats = 0;
      end else begin
        if (bus_if.we) st_beats++;
        if (valid) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid: o_valid=1 at cycle %0d with nothing outstanding (rdata=%h)", cyc, rdata);
          end else begin
            e = exp_q.pop_front();
            if (rdata !== e.rdata || error !== e.err || cyc != e.cyc || st_beats != e.beats) begin
              miscompares++;
              $display("FAIL completion: got rdata=%h err=%b cycle=%0d store_beats=%0d, expected rdata=%h err=%b cycle=%0d store_beats=%0d",
                       rdata, error, cyc, st_beats, e.rdata, e.err, e.cyc, e.beats);
            end
          end
          st_beats = 0;
        end
      end
    end
  end

  // Reference behaviour: expected completion computed from access size and alignment.
  task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] acc,
                       input logic u, input logic [31:0] wd, input bit track);
    int   guard = 0;
    int   size  = nbytes(acc);
    bit   mis   = (a % size) != 0;
    exp_t e;
    logic [31:0] v = '0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: o_ready=%b after %0d cycles, expected 1", ready, guard);
      return;
    end
    if (mis && !FEAT) begin
      e = '{rdata: 32'h0, err: 1'b1, cyc: cyc + 1, beats: 0};
    end else begin
      if (w) begin
        for (int i = 0; i < size; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (!u && size < 4 && v[8*size-1])
          for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
      end
      e = '{rdata: v, err: 1'b0, cyc: cyc + (mis ? size + 1 : 2), beats: w ? (mis ? size : 1) : 0};
    end
    if (track) exp_q.push_back(e);
    req = 1'b1; we = w; addr = a; access = acc; uns = u; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(ready), 32'd1);
    chk({tag, "_valid"},  32'(valid), 32'd0);
    chk({tag, "_rdata"},  rdata, 32'h0);
    chk({tag, "_error"},  32'(error), 32'd0);
    chk({tag, "_bus_we"}, 32'(bus_if.we), 32'd0);
    chk({tag, "_bus_addr"}, bus_if.addr, 32'h0);
    chk({tag, "_bus_access"}, 32'(bus_if.access), 32'd2);
    chk({tag, "_bus_wdata"}, bus_if.wdata, 32'h0);
  endtask

  initial begin
    logic [7:0] old [4];
    int mem_bad = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; access = 2'd2; uns = 1'b0; wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 8'hBB; mem[8'h11] = 8'hAA; mem[8'h12] = 8'h99; mem[8'h13] = 8'h88;
    for (int i = 16; i < 20; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h0000_0013, 2'd0, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h0000_0013, 2'd0, 1'b1, 32'h0, 1'b1);
    issue(1'b1, 32'h0000_0021, 2'd2, 1'b0, 32'h1122_3344, 1'b1);
    issue(1'b0, 32'h0000_0021, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'h0000_0031, 2'd1, 1'b0, 32'h0, 1'b1);
    issue(1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0000_BEEF, 1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b0, 32'h0, 1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, 32'h0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) ? 32'h0000_0180 : 32'hFFFF_FFF0) + 32'($urandom_range(0, 31)),
            2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end

    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d completions outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clk);

    // Reset lands on the second byte beat (split) or the only beat (aligned).
    if (FEAT) begin
      for (int i = 0; i < 4; i++) old[i] = ref_mem[8'h25 + i];
      issue(1'b1, 32'h0000_0025, 2'd2, 1'b0, 32'hA1B2_C3D4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      ref_mem[8'h25] = 8'hD4;
      ref_mem[8'h26] = 8'hC3;
      chk("abort_byte0", 32'(mem[8'h25]), 32'hD4);
      chk("abort_byte1", 32'(mem[8'h26]), 32'hC3);
      chk("abort_byte2", 32'(mem[8'h27]), 32'(old[2]));
      chk("abort_byte3", 32'(mem[8'h28]), 32'(old[3]));
    end else begin
      issue(1'b1, 32'h0000_0184, 2'd2, 1'b0, 32'hA1B2_C3D4, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) ref_mem[8'h84 + i] = 8'(32'hA1B2_C3D4 >> (8*i));
      chk("abort_word", {mem[8'h87], mem[8'h86], mem[8'h85], mem[8'h84]}, 32'hA1B2_C3D4);
    end
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_valid_bus_idle", 32'(bus_if.we), 32'd0);

    vectors++;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (mem_bad < 8) $display("FAIL mem_final[%0h]: got %h, expected %h", i, mem[i], ref_mem[i]);
        mem_bad++;
      end
    end
    if (mem_bad != 0) miscompares++;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
